axis_gain_ramp: RTL and testbench

AXIS_GAIN_RAMP -- requirements
Module: axis_gain_ramp

---
 rtl/axis_gain_ramp.sv | 133 +++++++++++++
 tb/tb_axis_gain_ramp.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/axis_gain_ramp.sv
// Gain ramp for a complex AXI-Stream sample path. Each accepted sample is paired with the current gain, which then steps toward the target.
// Optional macro GAIN_RAMP_PKT_ALIGN_EN defers target changes to packet boundaries.
module axis_gain_ramp #(
  parameter logic signed [15:0] INIT_GAIN = 16'sd0,
  parameter int                 WIDTH     = 16
) (
  input  logic                 ce_clk,
  input  logic                 ce_rst,
  input  logic [15:0]          target_gain,
  input  logic                 target_stb,
  input  logic [15:0]          step,
  input  logic [2*WIDTH-1:0]   i_tdata,
  input  logic                 i_tlast,
  input  logic                 i_tvalid,
  output logic                 i_tready,
  output logic [2*WIDTH-1:0]   o_tdata,
  output logic                 o_tlast,
  output logic                 o_tvalid,
  input  logic                 o_tready,
  output logic [15:0]          o_tgain,
  output logic                 ramping,
  output logic [1:0]           state
);

  // Handshake: a beat moves on any port when its valid and ready are both high at a rising edge.
  // The output register accepts a new beat whenever it is empty or being drained.
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] UP   = 2'd1;
  localparam logic [1:0] DOWN = 2'd2;

  logic               xfer;
  logic               load;
  logic signed [15:0] load_val;
  logic signed [15:0] cur_gain, tgt_gain;
  logic signed [15:0] cur_next, tgt_next, adv_gain;
  logic signed [17:0] cur_x, tgt_x, sum_up, sum_dn;
  logic [1:0]         state_next;

  assign i_tready = o_tready | ~o_tvalid;
  assign xfer     = i_tvalid & i_tready;

`ifdef GAIN_RAMP_PKT_ALIGN_EN
  logic signed [15:0] pend_gain;
  logic               pend_vld;

  // A strobe waits here until the packet in flight ends; a newer strobe replaces it.
  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      pend_gain <= INIT_GAIN;
      pend_vld  <= 1'b0;
    end else if (xfer && i_tlast) begin
      pend_vld  <= 1'b0;
    end else if (target_stb) begin
      pend_gain <= target_gain;
      pend_vld  <= 1'b1;
    end
  end

  assign load     = xfer & i_tlast & (pend_vld | target_stb);
  assign load_val = target_stb ? target_gain : pend_gain;
`else
  assign load     = target_stb;
  assign load_val = target_gain;
`endif

  // Ramp arithmetic is 18-bit signed so the step can never wrap past the target.
  always_comb begin
    cur_x  = {{2{cur_gain[15]}}, cur_gain};
    tgt_x  = {{2{tgt_gain[15]}}, tgt_gain};
    sum_up = cur_x + $signed({2'b00, step});
    sum_dn = cur_x - $signed({2'b00, step});
    adv_gain = cur_gain;
    case (state)
      UP:      adv_gain = (step == 16'd0 || sum_up >= tgt_x) ? tgt_gain : sum_up[15:0];
      DOWN:    adv_gain = (step == 16'd0 || sum_dn <= tgt_x) ? tgt_gain : sum_dn[15:0];
      default: adv_gain = cur_gain;
    endcase
  end

  // A new target never affects the beat it collides with; a zero step jumps at once.
  always_comb begin
    cur_next = cur_gain;
    tgt_next = tgt_gain;
    if (xfer) cur_next = adv_gain;
    if (load) begin
      tgt_next = load_val;
      if (step == 16'd0) cur_next = load_val;
    end
  end

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      cur_gain <= INIT_GAIN;
      tgt_gain <= INIT_GAIN;
    end else begin
      cur_gain <= cur_next;
      tgt_gain <= tgt_next;
    end
  end

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = IDLE;
    if (cur_next == tgt_next)     state_next = IDLE;
    else if (cur_next < tgt_next) state_next = UP;
    else                          state_next = DOWN;
  end

  always_comb begin
    ramping = (state != IDLE);
  end

  always_ff @(posedge ce_clk or posedge ce_rst) begin
    if (ce_rst) begin
      o_tvalid <= 1'b0;
      o_tlast  <= 1'b0;
      o_tdata  <= '0;
      o_tgain  <= INIT_GAIN;
    end else if (xfer) begin
      o_tvalid <= 1'b1;
      o_tlast  <= i_tlast;
      o_tdata  <= i_tdata;
      o_tgain  <= cur_gain;
    end else if (o_tready) begin
      o_tvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_gain_ramp.sv
// Directed bench for axis_gain_ramp built with INIT_GAIN=256; output beats are scored
// against an expected queue of {tlast, gain, data}.
module tb_axis_gain_ramp;
  localparam int WIDTH = 16;

  logic               ce_clk = 1'b0;
  logic               ce_rst;
  logic [15:0]        target_gain;
  logic               target_stb;
  logic [15:0]        step;
  logic [2*WIDTH-1:0] i_tdata;
  logic               i_tlast;
  logic               i_tvalid;
  logic               i_tready;
  logic [2*WIDTH-1:0] o_tdata;
  logic               o_tlast;
  logic               o_tvalid;
  logic               o_tready;
  logic [15:0]        o_tgain;
  logic               ramping;
  logic [1:0]         state;

  int          n_vec = 0;
  int          n_err = 0;
  logic        bp_en = 1'b0;
  logic [48:0] exp_q[$];

  axis_gain_ramp #(.INIT_GAIN(16'sd256), .WIDTH(WIDTH)) dut (
    .ce_clk(ce_clk), .ce_rst(ce_rst),
    .target_gain(target_gain), .target_stb(target_stb), .step(step),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .o_tgain(o_tgain), .ramping(ramping), .state(state)
  );

  always #5 ce_clk = ~ce_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_vec=%0d", n_vec);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [48:0] obs, input logic [48:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: score the output register at the falling edge, then advance.
  task automatic clk_step();
    @(negedge ce_clk);
    if (o_tvalid) begin
      if (exp_q.size() == 0) chk("spurious_valid", 49'(o_tvalid), 49'(0));
      else begin
        chk("out_beat", {o_tlast, o_tgain, o_tdata}, exp_q[0]);
        if (o_tready) void'(exp_q.pop_front());
      end
    end
    @(posedge ce_clk);
    #1;
    if (bp_en) o_tready = ~o_tready;
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic last, input logic [15:0] g);
    logic acc;
    acc = 1'b0;
    i_tdata  = d;
    i_tlast  = last;
    i_tvalid = 1'b1;
    exp_q.push_back({last, g, d});
    for (int k = 0; k < 16 && !acc; k++) begin
      acc = i_tready;
      clk_step();
    end
    chk("accepted", 49'(acc), 49'(1));
    i_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    i_tvalid = 1'b0;
    for (int k = 0; k < n; k++) clk_step();
  endtask

  task automatic strobe(input logic [15:0] tg, input logic [15:0] st);
    step        = st;
    target_gain = tg;
    target_stb  = 1'b1;
    clk_step();
    target_stb  = 1'b0;
  endtask

  initial begin
    ce_rst = 1'b1; target_gain = 16'd0; target_stb = 1'b0; step = 16'd0;
    i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0; o_tready = 1'b1;
    repeat (2) @(posedge ce_clk);
    #1;
    chk("rst_tvalid", 49'(o_tvalid), 49'(0));
    chk("rst_tlast", 49'(o_tlast), 49'(0));
    chk("rst_tdata", 49'(o_tdata), 49'(0));
    chk("rst_tgain", 49'(o_tgain), 49'(256));
    chk("rst_ramping", 49'(ramping), 49'(0));
    chk("rst_state", 49'(state), 49'(0));
    chk("rst_tready", 49'(i_tready), 49'(1));
    ce_rst = 1'b0;
    #1;
    chk("post_rst_tready", 49'(i_tready), 49'(1));

    // Four samples, no strobe: gain stays at INIT_GAIN, one cycle latency.
    send(32'hA000_0001, 1'b0, 16'd256);
    chk("latency_valid", 49'(o_tvalid), 49'(1));
    chk("latency_data", 49'(o_tdata), 49'(32'hA000_0001));
    send(32'hA000_0002, 1'b0, 16'd256);
    send(32'hA000_0003, 1'b0, 16'd256);
    send(32'hA000_0004, 1'b1, 16'd256);
    chk("flat_ramping", 49'(ramping), 49'(0));
    idle(2);
    chk("flat_drained", 49'(exp_q.size()), 49'(0));

`ifdef GAIN_RAMP_PKT_ALIGN_EN
    // Strobe at sample 2 of an 8-sample packet: ramp waits for the next packet.
    step = 16'd100;
    for (int k = 0; k < 8; k++) begin
      if (k == 1) begin target_gain = 16'd1000; target_stb = 1'b1; end
      send(32'hB000_0000 + 32'(k), (k == 7), 16'd256);
      target_stb = 1'b0;
      if (k == 4) chk("pkt_mid_ramping", 49'(ramping), 49'(0));
    end
    chk("pkt_boundary_ramping", 49'(ramping), 49'(1));
    send(32'hB100_0000, 1'b0, 16'd256);
    send(32'hB100_0001, 1'b0, 16'd356);
    send(32'hB100_0002, 1'b0, 16'd456);
    send(32'hB100_0003, 1'b1, 16'd556);
    idle(2);
    chk("pkt_drained", 49'(exp_q.size()), 49'(0));
`else
    // Up-ramp 256 -> 1000 by 300.
    strobe(16'd1000, 16'd300);
    chk("up_state", 49'(state), 49'(1));
    chk("up_ramping", 49'(ramping), 49'(1));
    send(32'h1111_0000, 1'b0, 16'd256);
    send(32'h1111_0001, 1'b0, 16'd556);
    chk("up_ramping_mid", 49'(ramping), 49'(1));
    send(32'h1111_0002, 1'b0, 16'd856);
    chk("up_ramping_done", 49'(ramping), 49'(0));
    send(32'h1111_0003, 1'b0, 16'd1000);
    send(32'h1111_0004, 1'b1, 16'd1000);
    idle(2);
    chk("up_drained", 49'(exp_q.size()), 49'(0));

    // Zero step jumps to 0 without ever ramping; then down-ramp to -100 under backpressure.
    strobe(16'd0, 16'd0);
    chk("jump_ramping", 49'(ramping), 49'(0));
    chk("jump_state", 49'(state), 49'(0));
    strobe(16'hFF9C, 16'd50);
    chk("down_state", 49'(state), 49'(2));
    bp_en = 1'b1;
    send(32'h2222_0000, 1'b0, 16'h0000);
    send(32'h2222_0001, 1'b0, 16'hFFCE);
    send(32'h2222_0002, 1'b0, 16'hFF9C);
    send(32'h2222_0003, 1'b1, 16'hFF9C);
    idle(4);
    bp_en = 1'b0;
    o_tready = 1'b1;
    idle(2);
    chk("down_drained", 49'(exp_q.size()), 49'(0));
    chk("down_ramping", 49'(ramping), 49'(0));

    // Zero-step strobe colliding with a transfer: that beat keeps -100, the next gets 512.
    step = 16'd0;
    target_gain = 16'd512;
    target_stb = 1'b1;
    send(32'h3333_0000, 1'b0, 16'hFF9C);
    target_stb = 1'b0;
    send(32'h3333_0001, 1'b1, 16'd512);
    chk("collide_ramping", 49'(ramping), 49'(0));
    idle(2);

    // Mid-ramp retarget reverses direction from the present gain.
    strobe(16'd300, 16'd100);
    chk("retgt_down_state", 49'(state), 49'(2));
    send(32'h4444_0000, 1'b0, 16'd512);
    send(32'h4444_0001, 1'b0, 16'd412);
    strobe(16'd600, 16'd100);
    chk("retgt_up_state", 49'(state), 49'(1));
    send(32'h4444_0002, 1'b0, 16'd312);
    send(32'h4444_0003, 1'b0, 16'd412);
    send(32'h4444_0004, 1'b0, 16'd512);
    send(32'h4444_0005, 1'b1, 16'd600);
    chk("retgt_ramping", 49'(ramping), 49'(0));
    strobe(16'd600, 16'd100);
    chk("same_tgt_state", 49'(state), 49'(0));
    idle(2);
    chk("retgt_drained", 49'(exp_q.size()), 49'(0));

    // Reset at sample 3 of a ramp 0 -> 2000 by 100.
    strobe(16'd0, 16'd0);
    strobe(16'd2000, 16'd100);
    send(32'h5555_0000, 1'b0, 16'd0);
    send(32'h5555_0001, 1'b0, 16'd100);
    i_tdata = 32'h5555_0002;
    i_tvalid = 1'b1;
    ce_rst = 1'b1;
    #1;
    chk("midrst_tvalid", 49'(o_tvalid), 49'(0));
    chk("midrst_tgain", 49'(o_tgain), 49'(256));
    chk("midrst_ramping", 49'(ramping), 49'(0));
    exp_q.delete();
    idle(1);
    chk("midrst_tready", 49'(i_tready), 49'(1));
    ce_rst = 1'b0;
    #1;
    chk("rel_tready", 49'(i_tready), 49'(1));
    chk("rel_tvalid", 49'(o_tvalid), 49'(0));
    chk("rel_state", 49'(state), 49'(0));
    send(32'h5555_0003, 1'b1, 16'd256);
    idle(2);
    chk("rel_drained", 49'(exp_q.size()), 49'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
